// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_pkg
// Description : Shared encodings for the data-memory load/store unit:
//               funct3 memory-op codes, FSM state codes, access-size
//               strobe patterns and the core data width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_lsu_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    // funct3 size/sign encodings as presented on the core's MemOp port
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    // Transaction FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RESP = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Access size is the low two bits of funct3; bit 2 only selects zero-extend
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Byte-enable pattern for an access at lane 0
    localparam logic [STRB_W-1:0] C_STRB_B = 8'h01;
    localparam logic [STRB_W-1:0] C_STRB_H = 8'h03;
    localparam logic [STRB_W-1:0] C_STRB_W = 8'h0F;
    localparam logic [STRB_W-1:0] C_STRB_D = 8'hFF;

    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] sz);
        logic [STRB_W-1:0] strb;
        case (sz)
            SZ_B:    strb = C_STRB_B;
            SZ_H:    strb = C_STRB_H;
            SZ_W:    strb = C_STRB_W;
            default: strb = C_STRB_D;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic for the load/store unit:
//               misalignment detection, store strobe/data lane shifting and
//               load-data extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]        st_size_i,
    input  logic [2:0]        st_off_i,
    input  logic [XLEN-1:0]   st_data_i,
    output logic              misalign_o,
    output logic [STRB_W-1:0] st_strb_o,
    output logic [XLEN-1:0]   st_data_o,
    input  logic [2:0]        ld_op_i,
    input  logic [2:0]        ld_off_i,
    input  logic [XLEN-1:0]   ld_raw_i,
    output logic [XLEN-1:0]   ld_data_o
);

    logic [XLEN-1:0] w_ld_shift;
    logic            w_ld_signed;

    // Natural-alignment check and store lane placement for the incoming access
    always_comb begin
        case (st_size_i)
            SZ_H:    misalign_o = st_off_i[0];
            SZ_W:    misalign_o = |st_off_i[1:0];
            SZ_D:    misalign_o = |st_off_i;
            default: misalign_o = 1'b0;
        endcase
        st_strb_o = size_strb(st_size_i) << st_off_i;
        st_data_o = st_data_i << {st_off_i, 3'b000};
    end

    // Bring the addressed bytes down to bit 0, then extend to full width
    always_comb begin
        w_ld_shift  = ld_raw_i >> {ld_off_i, 3'b000};
        w_ld_signed = ~ld_op_i[2];
        case (ld_op_i[1:0])
            SZ_B:    ld_data_o = {{(XLEN-8){w_ld_signed & w_ld_shift[7]}},   w_ld_shift[7:0]};
            SZ_H:    ld_data_o = {{(XLEN-16){w_ld_signed & w_ld_shift[15]}}, w_ld_shift[15:0]};
            SZ_W:    ld_data_o = {{(XLEN-32){w_ld_signed & w_ld_shift[31]}}, w_ld_shift[31:0]};
            default: ld_data_o = w_ld_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu
// Description : Load/store unit bridging the core's single-cycle data-memory
//               port to a valid/ready bus. Stalls the core for the duration
//               of one bus transaction and returns formatted load data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        mem_op_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              bus_req_valid_o,
    input  logic              bus_req_ready_i,
    output logic              bus_we_o,
    output logic [XLEN-1:0]   bus_addr_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [STRB_W-1:0] bus_wstrb_o,
    input  logic              bus_rsp_valid_i,
    input  logic              bus_rsp_err_i,
    input  logic [XLEN-1:0]   bus_rdata_i
);
    import dmem_lsu_pkg::*;

    logic [2:0]        state_q,         state_d;
    logic [2:0]        op_q,            op_d;
    logic [2:0]        off_q,           off_d;
    logic              bus_req_valid_q, bus_req_valid_d;
    logic              bus_we_q,        bus_we_d;
    logic [XLEN-1:0]   bus_addr_q,      bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q,     bus_wdata_d;
    logic [STRB_W-1:0] bus_wstrb_q,     bus_wstrb_d;
    logic [XLEN-1:0]   rdata_q,         rdata_d;
    logic              done_q,          done_d;
    logic              err_q,           err_d;

    logic              w_misalign;
    logic [STRB_W-1:0] w_st_strb;
    logic [XLEN-1:0]   w_st_data;
    logic [XLEN-1:0]   w_ld_data;

    // Store side works on the live core inputs (captured in IDLE);
    // load side works on the op/offset captured with the request.
    lsu_align u_align (
        .st_size_i  (mem_op_i[1:0]),
        .st_off_i   (addr_i[2:0]),
        .st_data_i  (wdata_i),
        .misalign_o (w_misalign),
        .st_strb_o  (w_st_strb),
        .st_data_o  (w_st_data),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_raw_i   (bus_rdata_i),
        .ld_data_o  (w_ld_data)
    );

    // Transaction sequencing and next values for every registered output
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        off_d           = off_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_we_d        = bus_we_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        bus_wstrb_d     = bus_wstrb_q;
        rdata_d         = rdata_q;
        done_d          = 1'b0;
        err_d           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d  = mem_op_i;
                    off_d = addr_i[2:0];
                    if (w_misalign) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d         = ST_REQ;
                        bus_req_valid_d = 1'b1;
                        bus_we_d        = mem_wr_i;
                        bus_addr_d      = {addr_i[XLEN-1:3], 3'b000};
                        // Loads present no byte enables and no write data
                        bus_wstrb_d     = mem_wr_i ? w_st_strb : '0;
                        bus_wdata_d     = mem_wr_i ? w_st_data : '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_req_ready_i) begin
                    bus_req_valid_d = 1'b0;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus_rsp_valid_i) begin
                    rdata_d = w_ld_data;
                    err_d   = bus_rsp_err_i;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            op_q            <= '0;
            off_q           <= '0;
            bus_req_valid_q <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= '0;
            bus_wdata_q     <= '0;
            bus_wstrb_q     <= '0;
            rdata_q         <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            off_q           <= off_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_we_q        <= bus_we_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wstrb_q     <= bus_wstrb_d;
            rdata_q         <= rdata_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign rdata_o         = rdata_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign bus_req_valid_o = bus_req_valid_q;
    assign bus_we_o        = bus_we_q;
    assign bus_addr_o      = bus_addr_q;
    assign bus_wdata_o     = bus_wdata_q;
    assign bus_wstrb_o     = bus_wstrb_q;
    assign stall_o         = req_valid_i && !done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu
// Description : Self-checking bench for dmem_lsu: directed vector table,
//               reset-in-flight sequence and randomized accesses checked
//               against a byte-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        mem_wr_i;
    logic [2:0]  mem_op_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        done_o;
    logic        stall_o;
    logic        err_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wstrb_o;
    logic        bus_rsp_valid_i;
    logic        bus_rsp_err_i;
    logic [63:0] bus_rdata_i;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0]  op;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] brdata;
        logic        berr;
        int          rdy;
        int          rsp;
        logic        exp_mis;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_strb;
        logic [63:0] exp_bwdata;
        int          exp_done;
    } vec_t;

    vec_t vecs [15];

    dmem_lsu #(.XLEN(64), .STRB_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .mem_wr_i        (mem_wr_i),
        .mem_op_i        (mem_op_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .rdata_o         (rdata_o),
        .done_o          (done_o),
        .stall_o         (stall_o),
        .err_o           (err_o),
        .bus_req_valid_o (bus_req_valid_o),
        .bus_req_ready_i (bus_req_ready_i),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_wstrb_o     (bus_wstrb_o),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_err_i   (bus_rsp_err_i),
        .bus_rdata_i     (bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    // Reference model: expected results from byte-level arithmetic on the access
    function automatic vec_t model(input logic [2:0] op, input logic wr, input logic [63:0] addr,
                                   input logic [63:0] wdata, input logic [63:0] brdata,
                                   input logic berr, input int rdy, input int rsp);
        vec_t        v;
        int          n;
        int          off;
        logic [63:0] mask;
        logic [63:0] val;
        v.op = op; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.brdata = brdata; v.berr = berr; v.rdy = rdy; v.rsp = rsp;
        n    = 1 << op[1:0];
        off  = int'(addr[2:0]);
        v.exp_mis = (off % n) != 0;
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        val  = (brdata >> (8 * off)) & mask;
        if (!op[2] && n < 8 && val[8 * n - 1]) val = val | ~mask;
        v.exp_rdata  = v.exp_mis ? 64'd0 : val;
        v.exp_err    = v.exp_mis | berr;
        v.exp_strb   = 8'(((1 << n) - 1) << off);
        v.exp_bwdata = wdata << (8 * off);
        v.exp_done   = v.exp_mis ? 3 : 4 + rdy + rsp;
        return v;
    endfunction

    // Drive one core access and act as the bus; cycle 1 is the first req_valid_i cycle
    task automatic do_access(input vec_t v, output int done_cyc, output logic [63:0] rdata,
                             output logic err, output logic [63:0] baddr, output logic bwe,
                             output logic [7:0] bstrb, output logic [63:0] bwdata,
                             output int stall_bad, output int unstable, output int req_seen);
        int vcnt;
        int rcnt;
        bit hs;
        bit first;
        @(posedge clk); #1;
        req_valid_i = 1'b1; mem_wr_i = v.wr; mem_op_i = v.op; addr_i = v.addr; wdata_i = v.wdata;
        done_cyc = 0; stall_bad = 0; unstable = 0; req_seen = 0;
        rdata = '0; err = 1'b0; baddr = '0; bwe = 1'b0; bstrb = '0; bwdata = '0;
        vcnt = 0; rcnt = 0; hs = 0; first = 1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            bus_req_ready_i = bus_req_valid_o && (vcnt >= v.rdy);
            bus_rsp_valid_i = hs && (rcnt == v.rsp);
            bus_rsp_err_i   = bus_rsp_valid_i ? v.berr : 1'($urandom);
            bus_rdata_i     = bus_rsp_valid_i ? v.brdata : {$urandom, $urandom};
            #1;
            if (bus_req_valid_o) begin
                req_seen++;
                if (first) begin
                    baddr = bus_addr_o; bwe = bus_we_o; bstrb = bus_wstrb_o; bwdata = bus_wdata_o;
                    first = 0;
                end else if (bus_addr_o !== baddr || bus_we_o !== bwe ||
                             bus_wstrb_o !== bstrb || bus_wdata_o !== bwdata) begin
                    unstable++;
                end
            end
            if (stall_o !== !done_o) stall_bad++;
            if (done_o === 1'b1) begin
                done_cyc = cyc; rdata = rdata_o; err = err_o;
                break;
            end
            if (hs) rcnt++;
            if (bus_req_valid_o && bus_req_ready_i) hs = 1;
            if (bus_req_valid_o) vcnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0; bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          done_cyc, stall_bad, unstable, req_seen;
        logic [63:0] rdata, baddr, bwdata;
        logic        err, bwe;
        logic [7:0]  bstrb;
        do_access(v, done_cyc, rdata, err, baddr, bwe, bstrb, bwdata, stall_bad, unstable, req_seen);
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        chk({tag, " err"}, {63'd0, err}, {63'd0, v.exp_err});
        chk({tag, " stall"}, 64'(stall_bad), 64'd0);
        if (!v.wr) chk({tag, " rdata"}, rdata, v.exp_rdata);
        if (v.exp_mis) begin
            chk({tag, " no_bus_req"}, 64'(req_seen), 64'd0);
        end else begin
            chk({tag, " bus_addr"}, baddr, {v.addr[63:3], 3'b000});
            chk({tag, " bus_we"}, {63'd0, bwe}, {63'd0, v.wr});
            chk({tag, " req_stable"}, 64'(unstable), 64'd0);
            if (v.wr) begin
                chk({tag, " wstrb"}, {56'd0, bstrb}, {56'd0, v.exp_strb});
                chk({tag, " wdata"}, bwdata, v.exp_bwdata);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " done"}, {63'd0, done_o}, 64'd0);
        chk({tag, " err"}, {63'd0, err_o}, 64'd0);
        chk({tag, " bus_req_valid"}, {63'd0, bus_req_valid_o}, 64'd0);
        chk({tag, " bus_we"}, {63'd0, bus_we_o}, 64'd0);
        chk({tag, " bus_addr"}, bus_addr_o, 64'd0);
        chk({tag, " bus_wdata"}, bus_wdata_o, 64'd0);
        chk({tag, " bus_wstrb"}, {56'd0, bus_wstrb_o}, 64'd0);
        chk({tag, " rdata"}, rdata_o, 64'd0);
    endtask

    initial begin
        //             op     wr addr              wdata                  brdata                 be rdy rsp mis exp_rdata              err strb   bwdata                 done
        vecs[0]  = '{3'b000, 0, 64'h8000_0003, 64'h0,                 64'h0000_0000_8000_0000, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 8'h00, 64'h0,                 4};
        vecs[1]  = '{3'b101, 0, 64'h8000_0006, 64'h0,                 64'hBEEF_0000_0000_0000, 0, 0, 0, 0, 64'h0000_0000_0000_BEEF, 0, 8'h00, 64'h0,                 4};
        vecs[2]  = '{3'b010, 1, 64'h8000_0004, 64'h1122_3344,         64'h0,                   0, 0, 0, 0, 64'h0,                   0, 8'hF0, 64'h1122_3344_0000_0000, 4};
        vecs[3]  = '{3'b011, 0, 64'h8000_0004, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 64'h0,                   1, 8'h00, 64'h0,                 3};
        vecs[4]  = '{3'b011, 1, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                 0, 5, 0, 0, 64'h0,                   0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 9};
        vecs[5]  = '{3'b010, 0, 64'h8000_000C, 64'h0,                 64'h8765_4321_0000_0000, 0, 1, 0, 0, 64'hFFFF_FFFF_8765_4321, 0, 8'h00, 64'h0,                 5};
        vecs[6]  = '{3'b110, 0, 64'h8000_000C, 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 1, 0, 64'h0000_0000_8765_4321, 0, 8'h00, 64'h0,                 5};
        vecs[7]  = '{3'b001, 0, 64'h8000_0002, 64'h0,                 64'h0000_0000_F00D_0000, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_F00D, 0, 8'h00, 64'h0,                 4};
        vecs[8]  = '{3'b100, 0, 64'h8000_0007, 64'h0,                 64'hA500_0000_0000_0000, 0, 0, 0, 0, 64'h0000_0000_0000_00A5, 0, 8'h00, 64'h0,                 4};
        vecs[9]  = '{3'b000, 1, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                 0, 0, 0, 0, 64'h0,                   0, 8'h20, 64'hFFFF_AB00_0000_0000, 4};
        vecs[10] = '{3'b001, 1, 64'h8000_0001, 64'h1234,              64'h0,                   0, 0, 0, 1, 64'h0,                   1, 8'h00, 64'h0,                 3};
        vecs[11] = '{3'b011, 0, 64'h8000_0010, 64'h0,                 64'h0,                   1, 0, 0, 0, 64'h0,                   1, 8'h00, 64'h0,                 4};
        vecs[12] = '{3'b111, 0, 64'h8000_0018, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 8'h00, 64'h0,                 4};
        vecs[13] = '{3'b010, 0, 64'h8000_0000, 64'h0,                 64'h0000_0000_7FFF_FFFF, 0, 0, 3, 0, 64'h0000_0000_7FFF_FFFF, 0, 8'h00, 64'h0,                 7};
        vecs[14] = '{3'b010, 1, 64'h8000_0002, 64'h5555,              64'h0,                   0, 0, 0, 1, 64'h0,                   1, 8'h00, 64'h0,                 3};

        rst_n = 1'b0; req_valid_i = 1'b0; mem_wr_i = 1'b0; mem_op_i = '0; addr_i = '0; wdata_i = '0;
        bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rdata_i = '0;
        #12;
        chk_all_zero("reset");
        chk("reset stall", {63'd0, stall_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset while waiting for a response; the late response must be ignored
        @(posedge clk); #1;
        req_valid_i = 1'b1; mem_wr_i = 1'b0; mem_op_i = 3'b010; addr_i = 64'h8000_0020; wdata_i = '0;
        bus_req_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("rstseq req_valid", {63'd0, bus_req_valid_o}, 64'd1);
        @(posedge clk); #1;
        chk("rstseq in_resp", {63'd0, bus_req_valid_o}, 64'd0);
        chk("rstseq addr_before", bus_addr_o, 64'h8000_0020);
        rst_n = 1'b0; req_valid_i = 1'b0; bus_req_ready_i = 1'b0;
        #1;
        chk_all_zero("rstseq");
        chk("rstseq stall", {63'd0, stall_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_rsp_valid_i = 1'b1; bus_rsp_err_i = 1'b1; bus_rdata_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rstseq stale_done", {63'd0, done_o}, 64'd0);
            chk("rstseq stale_err", {63'd0, err_o}, 64'd0);
            chk("rstseq stale_req", {63'd0, bus_req_valid_o}, 64'd0);
        end
        bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0;
        run_vec("rstseq next_lw", model(3'b010, 1'b0, 64'h8000_0020, 64'h0,
                                        64'h0000_0000_8000_0000, 1'b0, 0, 0));

        // Randomized accesses against the reference model
        for (int i = 0; i < 200; i++) begin
            vec_t v;
            v = model(3'($urandom_range(0, 7)), 1'($urandom), {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)},
                      {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            run_vec($sformatf("rand%0d", i), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
